// File: rtl/msg_index_sequencer_pkg.sv
// Shared types and default constants for the message index sequencer.
// State encodings and the default prescale divide live here for all users.
package msg_index_sequencer_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_TICK_DIV = 25_000_000;
  localparam int unsigned DEF_IDX_W    = 4;
  localparam int unsigned DEF_LAST     = 15;

endpackage

// File: rtl/msg_index_sequencer_if.sv
// Control inputs and index outputs of the message index sequencer.
// The dir signal exists only when SCROLL_DIR_EN is defined.
interface msg_index_sequencer_if #(
  parameter int unsigned IDX_W = 4
);
  logic             run;
  logic             step;
  logic             clr;
`ifdef SCROLL_DIR_EN
  logic             dir;
`endif
  logic [IDX_W-1:0] idx;
  logic             idx_stb;
  logic             wrap;
  logic             running;

`ifdef SCROLL_DIR_EN
  modport master (output run, step, clr, dir, input idx, idx_stb, wrap, running);
  modport slave  (input run, step, clr, dir, output idx, idx_stb, wrap, running);
`else
  modport master (output run, step, clr, input idx, idx_stb, wrap, running);
  modport slave  (input run, step, clr, output idx, idx_stb, wrap, running);
`endif
endinterface

// File: rtl/msg_index_sequencer_sync_edge.sv
// Multi-bit 2-FF synchroniser; bit 0 also gets a rising-edge detector.
module msg_index_sequencer_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync,
  output logic         rise_c
);

  logic [W-1:0] s1;
  logic         s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      sync <= '0;
      s3   <= 1'b0;
    end else begin
      s1   <= async_in;
      sync <= s1;
      s3   <= sync[0];
    end
  end

  assign rise_c = sync[0] & ~s3;

endmodule

// File: rtl/msg_index_sequencer.sv
// Message index sequencer: auto-advance in RUN, step-button advance in STOP.
// Define SCROLL_DIR_EN to add the synchronised dir input (1 = decrement).
module msg_index_sequencer
  import msg_index_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned IDX_W    = DEF_IDX_W,
  parameter int unsigned LAST     = DEF_LAST
) (
  input logic                  clk,
  input logic                  rst_n,
  msg_index_sequencer_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef SCROLL_DIR_EN
  localparam int unsigned SW = 3;
`else
  localparam int unsigned SW = 2;
`endif

  logic [SW-1:0]    raw;
  logic [SW-1:0]    sync;
  logic             stp_c;
  logic             run_s;
  logic             dec_c;
  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    presc;
  logic             tick_c;
  logic             adv_c;
  logic [IDX_W-1:0] idx_nxt;
  logic             wrap_nxt;

`ifdef SCROLL_DIR_EN
  assign raw   = {bus.dir, bus.run, bus.step};
  assign dec_c = sync[2];
`else
  assign raw   = {bus.run, bus.step};
  assign dec_c = 1'b0;
`endif
  assign run_s = sync[1];

  // Bit 0 (step) gets the edge detector; run and dir only use the sync path.
  msg_index_sequencer_sync_edge #(.W(SW)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (raw),
    .sync     (sync),
    .rise_c   (stp_c)
  );

  // Next state, advance decision and wrapped next index.
  always_comb begin
    state_nxt = run_s ? ST_RUN : ST_STOP;
    tick_c    = (state == ST_RUN) && run_s && (presc == PW'(TICK_DIV - 1));
    adv_c     = tick_c || (stp_c && (state == ST_STOP));
    idx_nxt   = bus.idx;
    wrap_nxt  = 1'b0;
    if (dec_c) begin
      if (bus.idx == '0) begin
        idx_nxt  = IDX_W'(LAST);
        wrap_nxt = 1'b1;
      end else begin
        idx_nxt = bus.idx - IDX_W'(1);
      end
    end else if (bus.idx == IDX_W'(LAST)) begin
      idx_nxt  = '0;
      wrap_nxt = 1'b1;
    end else begin
      idx_nxt = bus.idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_STOP;
      bus.running <= 1'b0;
      presc       <= '0;
      bus.idx     <= '0;
      bus.idx_stb <= 1'b0;
      bus.wrap    <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus.running <= (state_nxt == ST_RUN);
      // Prescaler only counts while running; clr and the terminal count restart it.
      if (bus.clr || (state != ST_RUN) || !run_s || (presc == PW'(TICK_DIV - 1))) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
      if (bus.clr) begin
        bus.idx     <= '0;
        bus.idx_stb <= 1'b0;
        bus.wrap    <= 1'b0;
      end else begin
        bus.idx_stb <= adv_c;
        bus.wrap    <= adv_c & wrap_nxt;
        if (adv_c) begin
          bus.idx <= idx_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_msg_index_sequencer.sv
// Scoreboard bench for msg_index_sequencer (TICK_DIV=4, LAST=15).
// Expected advances are queued with their cycle; a negedge monitor pops them on idx_stb.
module tb_msg_index_sequencer;
  import msg_index_sequencer_pkg::*;

  localparam int unsigned TD  = 4;
  localparam int unsigned IW  = 4;
  localparam int unsigned LST = 15;

  typedef struct {
    logic [IW-1:0] idx;
    logic          wrap;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msg_index_sequencer_if #(.IDX_W(IW)) bus ();

  msg_index_sequencer #(.TICK_DIV(TD), .IDX_W(IW), .LAST(LST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input bit wrap, input int at);
    exp_t e;
    e.idx  = IW'(idx);
    e.wrap = wrap;
    e.cyc  = at;
    q.push_back(e);
  endtask

  // Monitor: every strobe must match the next queued advance, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus.idx_stb === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_stb: got idx=%0d with empty queue (cycle %0d)", bus.idx, cyc);
        end else begin
          e = q.pop_front();
          check("stb_idx", 32'(bus.idx), 32'(e.idx));
          check("stb_wrap", 32'(bus.wrap), 32'(e.wrap));
          check("stb_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("wrap_without_stb", 32'(bus.wrap), 32'd0);
      end
    end
  end

  initial begin
    int c;
    int r;
    bus.run  = 1'b0;
    bus.step = 1'b0;
    bus.clr  = 1'b0;
`ifdef SCROLL_DIR_EN
    bus.dir  = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idx", 32'(bus.idx), 32'd0);
    check("rst_stb", 32'(bus.idx_stb), 32'd0);
    check("rst_wrap", 32'(bus.wrap), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_idx", 32'(bus.idx), 32'd0);
    check("idle_running", 32'(bus.running), 32'd0);

    // RUN for 70 cycles: first tick 7 edges after run rises, then every 4.
    c = cyc;
    bus.run = 1'b1;
    for (int k = 0; k < 17; k++) push((k + 1) % 16, ((k + 1) % 16) == 0, c + 7 + 4 * k);
    repeat (70) @(negedge clk);
    check("run_running", 32'(bus.running), 32'd1);
    bus.run = 1'b0;
    repeat (10) @(negedge clk);
    check("stop_running", 32'(bus.running), 32'd0);
    check("after_run_idx", 32'(bus.idx), 32'd1);

    // STOP: three held step presses, each exactly one advance 3 edges after rise.
    for (int i = 0; i < 3; i++) begin
      c = cyc;
      push(2 + i, 1'b0, c + 3);
      bus.step = 1'b1;
      repeat (10) @(negedge clk);
      bus.step = 1'b0;
      repeat (10) @(negedge clk);
    end
    check("after_step_idx", 32'(bus.idx), 32'd4);

    // clr coincides with the tick that would take idx 7 -> 8.
    c = cyc;
    bus.run = 1'b1;
    push(5, 1'b0, c + 7);
    push(6, 1'b0, c + 11);
    push(7, 1'b0, c + 15);
    repeat (18) @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("clr_idx", 32'(bus.idx), 32'd0);
    check("clr_stb", 32'(bus.idx_stb), 32'd0);
    for (int k = 1; k <= 9; k++) push(k, 1'b0, c + 19 + 4 * k);

    // Async reset mid-count at idx 9, then run resynchronises.
    repeat (38) @(negedge clk);
    check("pre_rst_idx", 32'(bus.idx), 32'd9);
    rst_n = 1'b0;
    #1;
    check("async_rst_idx", 32'(bus.idx), 32'd0);
    check("async_rst_running", 32'(bus.running), 32'd0);
    check("async_rst_stb", 32'(bus.idx_stb), 32'd0);
    repeat (2) @(negedge clk);
    r = cyc;
    rst_n = 1'b1;
    push(1, 1'b0, r + 7);
    push(2, 1'b0, r + 11);
    repeat (12) @(negedge clk);
    check("resync_running", 32'(bus.running), 32'd1);
    bus.run = 1'b0;
    repeat (8) @(negedge clk);
    check("after_resync_idx", 32'(bus.idx), 32'd2);

`ifdef SCROLL_DIR_EN
    // Decrementing step from 0 wraps to LAST.
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("dir_clr_idx", 32'(bus.idx), 32'd0);
    bus.dir = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      c = cyc;
      push(15 - i, i == 0, c + 3);
      bus.step = 1'b1;
      repeat (10) @(negedge clk);
      bus.step = 1'b0;
      repeat (10) @(negedge clk);
    end
    check("dir_idx", 32'(bus.idx), 32'd14);
`endif

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
